scan_seq: RTL and testbench

Row-scan sequencer that sits directly upstream of the 4-to-16 decoder (dec4_16). It produces the binary row address and the decoder enable. Each scan steps rows 0..last_row in turn. Every row is enabled for a programmable dwell time, with an optional blanking gap (enable low) between rows. Target uses: LED/keypad matrix scanning and time-multiplexed select generation.

---
 rtl/scan_seq.sv | 151 +++++++++++++++
 tb/tb_scan_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/scan_seq.sv
// Row-scan sequencer feeding a binary row address and enable to a 4-to-16 decoder.
// Rows 0..last_row are each enabled for a dwell time, optionally separated by blanking.
module scan_seq #(
   parameter int ADDR_W  = 4,
   parameter int DWELL_W = 8,
   parameter int BLANK_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               mode_cont,
   input  logic [ADDR_W-1:0]  last_row,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [BLANK_W-1:0] blank,
   output logic [ADDR_W-1:0]  addr,
   output logic               en,
   output logic               busy,
   output logic               row_strobe,
   output logic               frame_done
);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_BLANK} state_t;

   localparam logic [ADDR_W-1:0]  ONE_A = 1;
   localparam logic [DWELL_W-1:0] ONE_D = 1;
   localparam logic [BLANK_W-1:0] ONE_B = 1;

   state_t               state_q, state_n;
   logic                 cont_q, cont_n;
   logic [ADDR_W-1:0]    last_q, last_n;
   logic [DWELL_W-1:0]   dwell_q, dwell_n;
   logic [BLANK_W-1:0]   blank_q, blank_n;
   logic [DWELL_W-1:0]   dcnt_q, dcnt_n;
   logic [BLANK_W-1:0]   bcnt_q, bcnt_n;
   logic [ADDR_W-1:0]    addr_n;
   logic [ADDR_W-1:0]    next_row;
   logic                 row_end;

   // dcnt_q counts the enabled cycle within a row starting at 1, so the
   // row ends when it reaches the latched dwell (already clamped to >= 1).
   assign row_end  = (dcnt_q == dwell_q);
   assign next_row = (addr == last_q) ? '0 : addr + ONE_A;

   always_comb begin
      state_n = state_q;
      addr_n  = addr;
      dcnt_n  = dcnt_q;
      bcnt_n  = bcnt_q;
      cont_n  = cont_q;
      last_n  = last_q;
      dwell_n = dwell_q;
      blank_n = blank_q;
      case (state_q)
         S_IDLE: begin
            addr_n = '0;
            dcnt_n = '0;
            bcnt_n = '0;
            if (start && !stop) begin
               cont_n  = mode_cont;
               last_n  = last_row;
               dwell_n = (dwell == '0) ? ONE_D : dwell;
               blank_n = blank;
               state_n = S_ACTIVE;
               dcnt_n  = ONE_D;
            end
         end
         S_ACTIVE: begin
            if (stop) begin
               state_n = S_IDLE;
               addr_n  = '0;
               dcnt_n  = '0;
               bcnt_n  = '0;
            end else if (row_end) begin
               if ((addr != last_q) || cont_q) begin
                  if (blank_q != '0) begin
                     state_n = S_BLANK;
                     bcnt_n  = ONE_B;
                     dcnt_n  = '0;
                  end else begin
                     addr_n = next_row;
                     dcnt_n = ONE_D;
                  end
               end else begin
                  // single frame finished: no trailing blank
                  state_n = S_IDLE;
                  addr_n  = '0;
                  dcnt_n  = '0;
                  bcnt_n  = '0;
               end
            end else begin
               dcnt_n = dcnt_q + ONE_D;
            end
         end
         S_BLANK: begin
            if (stop) begin
               state_n = S_IDLE;
               addr_n  = '0;
               dcnt_n  = '0;
               bcnt_n  = '0;
            end else if (bcnt_q == blank_q) begin
               state_n = S_ACTIVE;
               addr_n  = next_row;
               dcnt_n  = ONE_D;
               bcnt_n  = '0;
            end else begin
               bcnt_n = bcnt_q + ONE_B;
            end
         end
         default: begin
            state_n = S_IDLE;
            addr_n  = '0;
            dcnt_n  = '0;
            bcnt_n  = '0;
         end
      endcase
   end

   // Outputs are registered from the next-state view so strobes line up
   // with the cycle they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr       <= '0;
         dcnt_q     <= '0;
         bcnt_q     <= '0;
         cont_q     <= 1'b0;
         last_q     <= '0;
         dwell_q    <= '0;
         blank_q    <= '0;
         en         <= 1'b0;
         busy       <= 1'b0;
         row_strobe <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_n;
         addr       <= addr_n;
         dcnt_q     <= dcnt_n;
         bcnt_q     <= bcnt_n;
         cont_q     <= cont_n;
         last_q     <= last_n;
         dwell_q    <= dwell_n;
         blank_q    <= blank_n;
         en         <= (state_n == S_ACTIVE);
         busy       <= (state_n != S_IDLE);
         row_strobe <= (state_n == S_ACTIVE) && (dcnt_n == ONE_D);
         frame_done <= (state_n == S_ACTIVE) && (dcnt_n == dwell_n) && (addr_n == last_n);
      end
   end

endmodule

// File: tb/tb_scan_seq.sv
// Scoreboard bench for scan_seq: stimulus queues hand-derived per-cycle outputs,
// a monitor pops one entry per clock and compares.
module tb_scan_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       mode_cont = 1'b0;
   logic [3:0] last_row = '0;
   logic [7:0] dwell = '0;
   logic [3:0] blank = '0;
   logic [3:0] addr;
   logic       en, busy, row_strobe, frame_done;

   typedef struct {
      logic [7:0] v;
      string      tag;
   } exp_t;

   exp_t  q[$];
   string tag = "reset";
   int    n_tests = 0;
   int    n_fail = 0;

   scan_seq #(.ADDR_W(4), .DWELL_W(8), .BLANK_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .mode_cont(mode_cont),
      .last_row(last_row), .dwell(dwell), .blank(blank),
      .addr(addr), .en(en), .busy(busy), .row_strobe(row_strobe), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // expected outputs for the cycle following the next rising edge
   task automatic ex(input logic [3:0] a, input logic e, input logic b,
                     input logic r, input logic f);
      exp_t x;
      x.v   = {a, e, b, r, f};
      x.tag = tag;
      q.push_back(x);
      @(posedge clk);
      #2;
   endtask

   initial begin
      exp_t       x;
      logic [7:0] got;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            x   = q.pop_front();
            got = {addr, en, busy, row_strobe, frame_done};
            n_tests++;
            if (got !== x.v) begin
               n_fail++;
               $display("FAIL %s: got addr=%0d en=%b busy=%b rs=%b fd=%b, want addr=%0d en=%b busy=%b rs=%b fd=%b",
                        x.tag, got[7:4], got[3], got[2], got[1], got[0],
                        x.v[7:4], x.v[3], x.v[2], x.v[1], x.v[0]);
            end
         end
      end
   end

   task automatic run_s1(input bit pert);
      tag = pert ? "latch_and_start" : "single_blank";
      dwell = 8'd3; blank = 4'd2; last_row = 4'd2; mode_cont = 1'b0; start = 1'b1;
      ex(0, 1, 1, 1, 0);
      start = 1'b0;
      if (pert) begin
         dwell = 8'd7; blank = 4'd0; last_row = 4'd5; mode_cont = 1'b1;
      end
      ex(0, 1, 1, 0, 0);
      if (pert) start = 1'b1;
      ex(0, 1, 1, 0, 0);
      start = 1'b0;
      ex(0, 0, 1, 0, 0); ex(0, 0, 1, 0, 0);
      ex(1, 1, 1, 1, 0); ex(1, 1, 1, 0, 0); ex(1, 1, 1, 0, 0);
      ex(1, 0, 1, 0, 0); ex(1, 0, 1, 0, 0);
      ex(2, 1, 1, 1, 0); ex(2, 1, 1, 0, 0); ex(2, 1, 1, 0, 1);
      ex(0, 0, 0, 0, 0);
      mode_cont = 1'b0;
      ex(0, 0, 0, 0, 0);
   endtask

   initial begin
      // reset state
      ex(0, 0, 0, 0, 0); ex(0, 0, 0, 0, 0);
      rst = 1'b0;
      ex(0, 0, 0, 0, 0);

      run_s1(1'b0);
      run_s1(1'b1);

      // continuous full sweep, one cycle per row, stop on the frame's last cycle
      tag = "full_sweep";
      dwell = 8'd0; blank = 4'd0; last_row = 4'd15; mode_cont = 1'b1; start = 1'b1;
      for (int f = 0; f < 2; f++)
         for (int r = 0; r < 16; r++) begin
            ex(4'(r), 1, 1, 1, (r == 15));
            start = 1'b0;
         end
      tag = "stop_at_frame_end";
      stop = 1'b1;
      ex(0, 0, 0, 0, 0);
      stop = 1'b0;
      ex(0, 0, 0, 0, 0);

      // abort on 2nd dwell cycle of row 1, then restart at row 0
      tag = "abort";
      dwell = 8'd4; blank = 4'd1; last_row = 4'd3; mode_cont = 1'b0; start = 1'b1;
      ex(0, 1, 1, 1, 0);
      start = 1'b0;
      ex(0, 1, 1, 0, 0); ex(0, 1, 1, 0, 0); ex(0, 1, 1, 0, 0);
      ex(0, 0, 1, 0, 0);
      ex(1, 1, 1, 1, 0); ex(1, 1, 1, 0, 0);
      stop = 1'b1;
      ex(0, 0, 0, 0, 0);
      stop = 1'b0;
      ex(0, 0, 0, 0, 0); ex(0, 0, 0, 0, 0);
      tag = "restart";
      start = 1'b1;
      ex(0, 1, 1, 1, 0);
      start = 1'b0;
      ex(0, 1, 1, 0, 0);
      stop = 1'b1;
      ex(0, 0, 0, 0, 0);
      stop = 1'b0;

      // start together with stop in IDLE
      tag = "start_stop_idle";
      start = 1'b1; stop = 1'b1;
      ex(0, 0, 0, 0, 0); ex(0, 0, 0, 0, 0);
      start = 1'b0; stop = 1'b0;

      // reset during the blank after row 3, continuous mode
      tag = "reset_mid";
      dwell = 8'd1; blank = 4'd2; last_row = 4'd5; mode_cont = 1'b1; start = 1'b1;
      for (int r = 0; r < 3; r++) begin
         ex(4'(r), 1, 1, 1, 0);
         start = 1'b0;
         ex(4'(r), 0, 1, 0, 0); ex(4'(r), 0, 1, 0, 0);
      end
      ex(3, 1, 1, 1, 0);
      ex(3, 0, 1, 0, 0);
      rst = 1'b1; start = 1'b1;
      ex(0, 0, 0, 0, 0);
      rst = 1'b0; start = 1'b0;
      ex(0, 0, 0, 0, 0);
      run_s1(1'b0);

      // single row, continuous, blank between every frame
      tag = "row0_loop";
      dwell = 8'd2; blank = 4'd1; last_row = 4'd0; mode_cont = 1'b1; start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ex(0, 1, 1, 1, 0);
         start = 1'b0;
         ex(0, 1, 1, 0, 1);
         ex(0, 0, 1, 0, 0);
      end
      tag = "stop_in_blank";
      stop = 1'b1;
      ex(0, 0, 0, 0, 0);
      stop = 1'b0;
      ex(0, 0, 0, 0, 0);

      @(posedge clk);
      #2;
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
